// File: rtl/wb_hid_report_fetcher.sv
// Pipelined Wishbone master that drains HID reports on interrupt: reads the ISR and
// the report words, clears the ISR by write-back, then offers the report on valid/ready.
module wb_hid_report_fetcher #(
  parameter logic [3:0]  ISR_ADR   = 4'h0,
  parameter logic [3:0]  RPT_BASE  = 4'h4,
  parameter int unsigned NUM_WORDS = 3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst_n,
  input  logic                      irq,
  output logic [3:0]                wbm_adr,
  output logic [31:0]               wbm_dat_w,
  input  logic [31:0]               wbm_dat_r,
  output logic [3:0]                wbm_sel,
  output logic                      wbm_cyc,
  output logic                      wbm_stb,
  output logic                      wbm_we,
  input  logic                      wbm_stall,
  input  logic                      wbm_ack,
  input  logic                      wbm_err,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [31:0]               rpt_isr,
  output logic [32*NUM_WORDS-1:0]   rpt_data,
  output logic [7:0]                err_cnt,
  output logic                      busy
);

  localparam int unsigned DW        = 32 * NUM_WORDS;
  localparam int unsigned HOW       = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [2:0]  LAST_WORD = 3'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_ISR, S_RD_RPT, S_WR_CLR, S_OUT} state_t;

  state_t          r_state, state_nxt;
  logic [3:0]      r_adr, adr_nxt;
  logic [31:0]     r_dat_w, dat_w_nxt;
  logic [3:0]      r_sel, sel_nxt;
  logic            r_cyc, cyc_nxt;
  logic            r_stb, stb_nxt;
  logic            r_we, we_nxt;
  logic [31:0]     r_isr, isr_nxt;
  logic [DW-1:0]   r_buf, buf_nxt;
  logic [2:0]      r_wcnt, wcnt_nxt;
  logic [7:0]      r_tmo, tmo_nxt;
  logic [HOW-1:0]  r_hold, hold_nxt;
  logic [7:0]      r_err_cnt, err_cnt_nxt;
  logic            r_rpt_valid, rpt_valid_nxt;
  logic [31:0]     r_rpt_isr, rpt_isr_nxt;
  logic [DW-1:0]   r_rpt_data, rpt_data_nxt;
  logic            r_busy, busy_nxt;
  logic            r_armed;

  logic w_accept, w_ack, w_err, w_tmo, w_abort, w_bus_clr;

  // Bus responses only count while a cycle is open; err wins over ack
  assign w_accept = r_stb & ~wbm_stall;
  assign w_ack    = r_cyc & wbm_ack & ~wbm_err;
  assign w_err    = r_cyc & wbm_err;
  assign w_tmo    = r_cyc & ~w_accept & ~wbm_ack & ~wbm_err &
                    (({1'b0, r_tmo} + 9'd1) >= 9'(TIMEOUT));
  assign w_abort  = w_err | w_tmo;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state     <= S_IDLE;
      r_adr       <= '0;
      r_dat_w     <= '0;
      r_sel       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_isr       <= '0;
      r_buf       <= '0;
      r_wcnt      <= '0;
      r_tmo       <= '0;
      r_hold      <= '0;
      r_err_cnt   <= '0;
      r_rpt_valid <= 1'b0;
      r_rpt_isr   <= '0;
      r_rpt_data  <= '0;
      r_busy      <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= state_nxt;
      r_adr       <= adr_nxt;
      r_dat_w     <= dat_w_nxt;
      r_sel       <= sel_nxt;
      r_cyc       <= cyc_nxt;
      r_stb       <= stb_nxt;
      r_we        <= we_nxt;
      r_isr       <= isr_nxt;
      r_buf       <= buf_nxt;
      r_wcnt      <= wcnt_nxt;
      r_tmo       <= tmo_nxt;
      r_hold      <= hold_nxt;
      r_err_cnt   <= err_cnt_nxt;
      r_rpt_valid <= rpt_valid_nxt;
      r_rpt_isr   <= rpt_isr_nxt;
      r_rpt_data  <= rpt_data_nxt;
      r_busy      <= busy_nxt;
      r_armed     <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = r_state;
    adr_nxt       = r_adr;
    dat_w_nxt     = r_dat_w;
    sel_nxt       = r_sel;
    cyc_nxt       = r_cyc;
    stb_nxt       = r_stb;
    we_nxt        = r_we;
    isr_nxt       = r_isr;
    buf_nxt       = r_buf;
    wcnt_nxt      = r_wcnt;
    tmo_nxt       = r_tmo;
    hold_nxt      = (r_hold != '0) ? r_hold - HOW'(1) : r_hold;
    err_cnt_nxt   = r_err_cnt;
    rpt_valid_nxt = r_rpt_valid;
    rpt_isr_nxt   = r_rpt_isr;
    rpt_data_nxt  = r_rpt_data;
    w_bus_clr     = 1'b0;

    // Timeout counter restarts on acceptance and runs while the cycle is open
    if (r_cyc) begin
      if (w_accept) begin
        stb_nxt = 1'b0;
        tmo_nxt = '0;
      end else begin
        tmo_nxt = r_tmo + 8'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (r_armed && irq && !r_rpt_valid && (r_hold == '0)) begin
          state_nxt = S_RD_ISR;
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = 1'b0;
          sel_nxt   = 4'hF;
          adr_nxt   = ISR_ADR;
          dat_w_nxt = '0;
          tmo_nxt   = '0;
        end
      end
      S_RD_ISR, S_RD_RPT, S_WR_CLR: begin
        if (w_abort) begin
          state_nxt   = S_IDLE;
          w_bus_clr   = 1'b1;
          hold_nxt    = HOW'(HOLDOFF);
          err_cnt_nxt = (r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
        end else if (w_ack) begin
          stb_nxt = 1'b1;
          tmo_nxt = '0;
          if (r_state == S_RD_ISR) begin
            if (wbm_dat_r == 32'd0) begin
              state_nxt = S_IDLE;
              w_bus_clr = 1'b1;
            end else begin
              state_nxt = S_RD_RPT;
              isr_nxt   = wbm_dat_r;
              wcnt_nxt  = '0;
              adr_nxt   = RPT_BASE;
            end
          end else if (r_state == S_RD_RPT) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
              if (r_wcnt == 3'(k)) buf_nxt[32*k +: 32] = wbm_dat_r;
            end
            if (r_wcnt == LAST_WORD) begin
              state_nxt = S_WR_CLR;
              adr_nxt   = ISR_ADR;
              we_nxt    = 1'b1;
              dat_w_nxt = r_isr;
            end else begin
              wcnt_nxt = r_wcnt + 3'd1;
              adr_nxt  = RPT_BASE + 4'(r_wcnt) + 4'd1;
            end
          end else begin
            state_nxt     = S_OUT;
            w_bus_clr     = 1'b1;
            hold_nxt      = HOW'(HOLDOFF);
            rpt_valid_nxt = 1'b1;
            rpt_isr_nxt   = r_isr;
            rpt_data_nxt  = r_buf;
          end
        end
      end
      S_OUT: begin
        if (r_rpt_valid && rpt_ready) begin
          rpt_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (w_bus_clr) begin
      cyc_nxt   = 1'b0;
      stb_nxt   = 1'b0;
      we_nxt    = 1'b0;
      sel_nxt   = '0;
      adr_nxt   = '0;
      dat_w_nxt = '0;
      tmo_nxt   = '0;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  assign wbm_adr   = r_adr;
  assign wbm_dat_w = r_dat_w;
  assign wbm_sel   = r_sel;
  assign wbm_cyc   = r_cyc;
  assign wbm_stb   = r_stb;
  assign wbm_we    = r_we;
  assign rpt_valid = r_rpt_valid;
  assign rpt_isr   = r_rpt_isr;
  assign rpt_data  = r_rpt_data;
  assign err_cnt   = r_err_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_wb_hid_report_fetcher.sv
// Bench for wb_hid_report_fetcher: negedge Wishbone slave with stall/err/no-ack knobs,
// transaction log checked against a fetch-sequence model built from register contents.
module tb_wb_hid_report_fetcher;

  localparam logic [3:0]  ISR_ADR   = 4'h0;
  localparam logic [3:0]  RPT_BASE  = 4'h4;
  localparam int unsigned NUM_WORDS = 3;
  localparam int unsigned TIMEOUT   = 255;
  localparam int unsigned HOLDOFF   = 4;

  typedef struct packed {
    logic [3:0]  adr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  logic                     wb_clk = 1'b0;
  logic                     wb_rst_n;
  logic                     irq;
  logic [3:0]               wbm_adr;
  logic [31:0]              wbm_dat_w;
  logic [31:0]              wbm_dat_r;
  logic [3:0]               wbm_sel;
  logic                     wbm_cyc, wbm_stb, wbm_we;
  logic                     wbm_stall, wbm_ack, wbm_err;
  logic                     rpt_valid, rpt_ready;
  logic [31:0]              rpt_isr;
  logic [32*NUM_WORDS-1:0]  rpt_data;
  logic [7:0]               err_cnt;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [16];
  int   stall_cfg  = 0;
  bit   no_ack     = 0;
  bit   err_all    = 0;
  int   err_on_rpt = 0;
  bit   stray      = 0;
  txn_t log_q[$];

  int          stall_left = 0;
  bit          pend = 0, pend_err = 0, stalling = 0;
  logic [31:0] pend_dat;
  int          rpt_rd_cnt = 0;
  txn_t        st_txn;

  wb_hid_report_fetcher #(
    .ISR_ADR(ISR_ADR), .RPT_BASE(RPT_BASE), .NUM_WORDS(NUM_WORDS),
    .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .irq(irq),
    .wbm_adr(wbm_adr), .wbm_dat_w(wbm_dat_w), .wbm_dat_r(wbm_dat_r),
    .wbm_sel(wbm_sel), .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we),
    .wbm_stall(wbm_stall), .wbm_ack(wbm_ack), .wbm_err(wbm_err),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_isr(rpt_isr),
    .rpt_data(rpt_data), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  // Slave: decides stall/ack/err at negedge for the following rising edge
  always @(negedge wb_clk) begin
    wbm_ack   = 1'b0;
    wbm_err   = 1'b0;
    wbm_stall = 1'b0;
    wbm_dat_r = $urandom;
    if (!wb_rst_n || !wbm_cyc) begin
      pend       = 0;
      stalling   = 0;
      stall_left = stall_cfg;
      rpt_rd_cnt = 0;
    end
    if (stray) begin
      wbm_ack = 1'b1;
      wbm_err = 1'b1;
      stray   = 0;
    end
    if (wb_rst_n && pend && !no_ack) begin
      wbm_ack    = !pend_err;
      wbm_err    = pend_err;
      wbm_dat_r  = pend_dat;
      pend       = 0;
      stall_left = stall_cfg;
    end
    if (wb_rst_n && wbm_cyc && wbm_stb && !pend) begin
      if (stalling) chk("stall_hold", 128'({wbm_adr, wbm_we, wbm_dat_w}), 128'(st_txn));
      else st_txn = '{wbm_adr, wbm_we, wbm_dat_w};
      if (stall_left > 0) begin
        wbm_stall = 1'b1;
        stall_left--;
        stalling = 1;
      end else begin
        stalling = 0;
        chk("sel", 128'(wbm_sel), 128'(4'hF));
        log_q.push_back('{wbm_adr, wbm_we, wbm_dat_w});
        pend = 1;
        if (wbm_we) begin
          pend_dat = 32'd0;
          pend_err = err_all;
        end else begin
          pend_dat = mem[wbm_adr];
          if (wbm_adr >= RPT_BASE && wbm_adr < RPT_BASE + 4'(NUM_WORDS)) rpt_rd_cnt++;
          pend_err = err_all || (err_on_rpt != 0 && rpt_rd_cnt == err_on_rpt);
        end
      end
    end else if (stalling) begin
      chk("stall_stb", 128'(wbm_stb), 128'(1));
      stalling = 0;
    end
  end

  // Runs one fetch and compares bus traffic and report against the model
  task automatic run_fetch(input string tag, input bit started, input int ready_dly,
                           input bit check_hold);
    txn_t         exp_q[$];
    logic [127:0] exp_data;
    logic [31:0]  isr;
    int           n;
    isr      = mem[ISR_ADR];
    exp_data = '0;
    exp_q.push_back('{ISR_ADR, 1'b0, 32'd0});
    if (isr != 0) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        exp_q.push_back('{RPT_BASE + 4'(k), 1'b0, 32'd0});
        exp_data[32*k +: 32] = mem[RPT_BASE + 4'(k)];
      end
      exp_q.push_back('{ISR_ADR, 1'b1, isr});
    end
    if (!started) begin
      log_q.delete();
      irq = 1'b1;
    end
    n = 0;
    while (!busy && n < 50) begin tick(); n++; end
    chk({tag, "_start"}, 128'(busy), 128'(1));
    if (!check_hold) irq = 1'b0;
    if (isr == 0) begin
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk({tag, "_spur_idle"}, 128'(busy), 128'(0));
      chk({tag, "_spur_valid"}, 128'(rpt_valid), 128'(0));
    end else begin
      n = 0;
      while (!rpt_valid && n < 300) begin tick(); n++; end
      chk({tag, "_valid"}, 128'(rpt_valid), 128'(1));
      chk({tag, "_isr"}, 128'(rpt_isr), 128'(isr));
      chk({tag, "_data"}, 128'(rpt_data), exp_data);
      if (check_hold) begin
        repeat (10) tick();
        chk({tag, "_hold_cyc"}, 128'(wbm_cyc), 128'(0));
        chk({tag, "_hold_valid"}, 128'(rpt_valid), 128'(1));
        chk({tag, "_hold_txns"}, 128'(log_q.size()), 128'(exp_q.size()));
        irq = 1'b0;
      end
      repeat (ready_dly) tick();
      chk({tag, "_still_valid"}, 128'(rpt_valid), 128'(1));
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      chk({tag, "_hs_valid"}, 128'(rpt_valid), 128'(0));
      chk({tag, "_hs_busy"}, 128'(busy), 128'(0));
    end
    chk({tag, "_ntxn"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), 128'(log_q[i].adr), 128'(exp_q[i].adr));
      chk($sformatf("%s_we%0d", tag, i), 128'(log_q[i].we), 128'(exp_q[i].we));
      if (exp_q[i].we) chk($sformatf("%s_wdat%0d", tag, i), 128'(log_q[i].dat), 128'(exp_q[i].dat));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cyc"}, 128'(wbm_cyc), 128'(0));
    chk({tag, "_stb"}, 128'(wbm_stb), 128'(0));
    chk({tag, "_we"}, 128'(wbm_we), 128'(0));
    chk({tag, "_adr"}, 128'(wbm_adr), 128'(0));
    chk({tag, "_datw"}, 128'(wbm_dat_w), 128'(0));
    chk({tag, "_sel"}, 128'(wbm_sel), 128'(0));
    chk({tag, "_valid"}, 128'(rpt_valid), 128'(0));
    chk({tag, "_isr"}, 128'(rpt_isr), 128'(0));
    chk({tag, "_data"}, 128'(rpt_data), 128'(0));
    chk({tag, "_errcnt"}, 128'(err_cnt), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, abort_n;
    wb_rst_n  = 1'b0;
    irq       = 1'b0;
    rpt_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h1; mem[4] = 32'hA; mem[5] = 32'hB; mem[6] = 32'hC;
    repeat (3) tick();
    check_zero("reset");

    // irq pending across reset release: first edge must not start a fetch
    irq = 1'b1;
    tick();
    chk("rst_hold_cyc", 128'(wbm_cyc), 128'(0));
    log_q.delete();
    wb_rst_n = 1'b1;
    tick();
    chk("first_edge_cyc", 128'(wbm_cyc), 128'(0));
    run_fetch("basic", 1, 2, 1);

    stall_cfg = 3;
    run_fetch("stall3", 0, 0, 0);
    stall_cfg = 0;

    mem[0] = 32'h0;
    run_fetch("spurious", 0, 0, 0);

    stray = 1;
    repeat (3) tick();
    chk("stray_errcnt", 128'(err_cnt), 128'(0));
    chk("stray_busy", 128'(busy), 128'(0));

    // Bus error on the second report read
    mem[0] = 32'h5;
    err_on_rpt = 2;
    log_q.delete();
    irq = 1'b1;
    n = 0;
    while (wbm_err !== 1'b1 && n < 100) begin tick(); n++; end
    chk("err_seen", 128'(wbm_err), 128'(1));
    chk("err_cyc", 128'(wbm_cyc), 128'(0));
    chk("err_stb", 128'(wbm_stb), 128'(0));
    chk("err_cnt1", 128'(err_cnt), 128'(1));
    chk("err_valid", 128'(rpt_valid), 128'(0));
    chk("err_ntxn", 128'(log_q.size()), 128'(3));
    err_on_rpt = 0;
    log_q.delete();
    gap = 0;
    while (!wbm_cyc && gap < 50) begin gap++; tick(); end
    chk("err_holdoff_gap", 128'(gap), 128'(HOLDOFF + 1));
    run_fetch("err_refetch", 1, 1, 0);

    // Slave never acks
    no_ack = 1;
    mem[0] = 32'h7;
    irq = 1'b1;
    n = 0;
    while (!wbm_cyc && n < 50) begin tick(); n++; end
    n = 0;
    while (wbm_cyc && n < 400) begin n++; tick(); end
    irq = 1'b0;
    chk("tmo_cyc_len", 128'(n), 128'(TIMEOUT + 1));
    chk("tmo_errcnt", 128'(err_cnt), 128'(2));
    chk("tmo_valid", 128'(rpt_valid), 128'(0));
    no_ack = 0;

    // Drive the abort count to 256 and watch saturation
    err_all = 1;
    irq = 1'b1;
    for (int i = 0; i < 254; i++) begin
      n = 0;
      while (!wbm_cyc && n < 30) begin tick(); n++; end
      n = 0;
      while (wbm_cyc && n < 30) begin tick(); n++; end
      abort_n = i + 3;
      chk($sformatf("sat_%0d", abort_n), 128'(err_cnt),
          128'((abort_n > 255) ? 255 : abort_n));
    end
    irq = 1'b0;
    err_all = 0;
    repeat (HOLDOFF + 2) tick();

    for (int r = 0; r < 6; r++) begin
      mem[0] = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'h1);
      for (int k = 0; k < NUM_WORDS; k++) mem[RPT_BASE + 4'(k)] = $urandom;
      stall_cfg = $urandom_range(0, 3);
      run_fetch($sformatf("rnd%0d", r), 0, $urandom_range(0, 4), 0);
      repeat (HOLDOFF + 1) tick();
    end
    stall_cfg = 0;

    // Reset asserted while a report read is stalled
    mem[0] = 32'h9;
    stall_cfg = 20;
    irq = 1'b1;
    n = 0;
    while (!(wbm_cyc && wbm_adr == RPT_BASE + 4'd1) && n < 200) begin tick(); n++; end
    chk("mid_rpt_reached", 128'(wbm_adr), 128'(RPT_BASE + 4'd1));
    wb_rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    irq = 1'b0;
    stall_cfg = 0;
    repeat (2) tick();
    wb_rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_busy", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
